// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: classifies a RISC-V instruction by opcode,
// extracts and extends its immediate, and registers the result behind a
// ready/valid handshake with single-cycle latency. It also keeps a saturating
// count of accepted instructions whose opcode is not in the decode table.
module imm_decode_stage #(
    parameter int XLEN        = 32,
    parameter bit ENABLE_ZIMM = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_insn,
    output logic [2:0]       out_imm_src,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_NONE = 3'b111
    } imm_src_e;

    logic [6:0]       w_opcode;
    imm_src_e         w_imm_src;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic             w_illegal;
    logic             w_accept;

    logic             r_valid;
    logic [31:0]      r_insn;
    imm_src_e         r_imm_src;
    logic [XLEN-1:0]  r_imm;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_opcode = in_insn[6:0];

    // Every format is first assembled as a 32-bit signed value; the zimm field
    // is placed with bit 31 clear so the common widening below zero-extends it.
    always_comb begin
        w_imm_src = IMM_NONE;
        w_imm32   = 32'h0;
        w_illegal = 1'b0;
        case (w_opcode)
            OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE: begin
                w_imm_src = IMM_I;
                w_imm32   = {{20{in_insn[31]}}, in_insn[31:20]};
            end
            OP_STORE: begin
                w_imm_src = IMM_S;
                w_imm32   = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
            end
            OP_BRANCH: begin
                w_imm_src = IMM_B;
                w_imm32   = {{19{in_insn[31]}}, in_insn[31], in_insn[7],
                             in_insn[30:25], in_insn[11:8], 1'b0};
            end
            OP_JAL: begin
                w_imm_src = IMM_J;
                w_imm32   = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12],
                             in_insn[20], in_insn[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_imm_src = IMM_U;
                w_imm32   = {in_insn[31:12], 12'h000};
            end
            OP_SYSTEM: begin
                if (ENABLE_ZIMM) begin
                    w_imm_src = IMM_Z;
                    w_imm32   = {27'h0, in_insn[19:15]};
                end
            end
            OP_OP: begin
                w_imm_src = IMM_NONE;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // Output register and illegal counter: reset, then flush, then accept, then drain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_insn    <= 32'h0;
            r_imm_src <= IMM_NONE;
            r_imm     <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_insn    <= in_insn;
            r_imm_src <= w_imm_src;
            r_imm     <= w_imm;
            r_illegal <= w_illegal;
            if (w_illegal && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_insn    = r_insn;
    assign out_imm_src = r_imm_src;
    assign out_imm     = r_imm;
    assign out_illegal = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage. Two instances share one input
// stream: d0 is XLEN=32 with a 2-bit counter and zimm decode enabled, d1 is
// XLEN=64 with an 8-bit counter and zimm decode disabled.
module tb_imm_decode_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        inValid;
    logic [31:0] inInsn;
    logic        outReady;

    logic        d0InReady, d0OutValid, d0OutIllegal;
    logic [31:0] d0OutInsn, d0OutImm;
    logic [2:0]  d0OutImmSrc;
    logic [1:0]  d0IllegalCnt;

    logic        d1InReady, d1OutValid, d1OutIllegal;
    logic [31:0] d1OutInsn;
    logic [63:0] d1OutImm;
    logic [2:0]  d1OutImmSrc;
    logic [7:0]  d1IllegalCnt;

    int checks = 0;
    int errors = 0;

    imm_decode_stage #(.XLEN(32), .ENABLE_ZIMM(1'b1), .CNT_W(2)) dut0 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(inValid), .in_ready(d0InReady), .in_insn(inInsn),
        .out_valid(d0OutValid), .out_ready(outReady), .out_insn(d0OutInsn),
        .out_imm_src(d0OutImmSrc), .out_imm(d0OutImm),
        .out_illegal(d0OutIllegal), .illegal_cnt(d0IllegalCnt)
    );

    imm_decode_stage #(.XLEN(64), .ENABLE_ZIMM(1'b0), .CNT_W(8)) dut1 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(inValid), .in_ready(d1InReady), .in_insn(inInsn),
        .out_valid(d1OutValid), .out_ready(outReady), .out_insn(d1OutInsn),
        .out_imm_src(d1OutImmSrc), .out_imm(d1OutImm),
        .out_illegal(d1OutIllegal), .illegal_cnt(d1IllegalCnt)
    );

    // Free-running 10 ns clock; stimulus and sampling both happen on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [31:0] insn,
                                 input logic rdy, input logic fl);
        inValid  = v;
        inInsn   = insn;
        outReady = rdy;
        flush    = fl;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", d0OutValid); end
        checks++; if (d0OutInsn !== 32'h0) begin errors++; $display("[TB] FAIL reset out_insn: got %h want 0", d0OutInsn); end
        checks++; if (d0OutImmSrc !== 3'b111) begin errors++; $display("[TB] FAIL reset imm_src: got %b want 111", d0OutImmSrc); end
        checks++; if (d1OutImm !== 64'h0) begin errors++; $display("[TB] FAIL reset imm64: got %h want 0", d1OutImm); end
        checks++; if (d0OutIllegal !== 1'b0) begin errors++; $display("[TB] FAIL reset illegal: got %b want 0", d0OutIllegal); end
        checks++; if (d1IllegalCnt !== 8'd0) begin errors++; $display("[TB] FAIL reset cnt: got %0d want 0", d1IllegalCnt); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (d0InReady !== 1'b1) begin errors++; $display("[TB] FAIL post-reset in_ready: got %b want 1", d0InReady); end
    endtask

    task automatic test_i_type();
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b1) begin errors++; $display("[TB] FAIL addi valid: got %b want 1", d0OutValid); end
        checks++; if (d0OutImmSrc !== 3'b000) begin errors++; $display("[TB] FAIL addi imm_src: got %b want 000", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL addi imm32: got %h want ffffffff", d0OutImm); end
        checks++; if (d1OutImm !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("[TB] FAIL addi imm64: got %h want all ones", d1OutImm); end
        checks++; if (d0OutInsn !== 32'hFFF00093) begin errors++; $display("[TB] FAIL addi insn: got %h want fff00093", d0OutInsn); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL drain valid: got %b want 0", d0OutValid); end
    endtask

    task automatic test_s_b_type();
        applyStimulus(1'b1, 32'h0020A423, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutImmSrc !== 3'b001) begin errors++; $display("[TB] FAIL sw imm_src: got %b want 001", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'h00000008) begin errors++; $display("[TB] FAIL sw imm: got %h want 00000008", d0OutImm); end
        applyStimulus(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b1) begin errors++; $display("[TB] FAIL beq valid: got %b want 1", d0OutValid); end
        checks++; if (d0OutImmSrc !== 3'b010) begin errors++; $display("[TB] FAIL beq imm_src: got %b want 010", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL beq imm: got %h want fffffffc", d0OutImm); end
        checks++; if (d1OutImm !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("[TB] FAIL beq imm64: got %h want fffffffffffffffc", d1OutImm); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_u_type();
        applyStimulus(1'b1, 32'h123452B7, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d1OutImmSrc !== 3'b100) begin errors++; $display("[TB] FAIL lui imm_src: got %b want 100", d1OutImmSrc); end
        checks++; if (d1OutImm !== 64'h0000000012345000) begin errors++; $display("[TB] FAIL lui imm64: got %h want 0000000012345000", d1OutImm); end
        checks++; if (d0OutImm !== 32'h12345000) begin errors++; $display("[TB] FAIL lui imm32: got %h want 12345000", d0OutImm); end
        applyStimulus(1'b1, 32'h800000B7, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d1OutImm !== 64'hFFFFFFFF80000000) begin errors++; $display("[TB] FAIL lui neg imm64: got %h want ffffffff80000000", d1OutImm); end
        checks++; if (d0OutImm !== 32'h80000000) begin errors++; $display("[TB] FAIL lui neg imm32: got %h want 80000000", d0OutImm); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_j_type();
        applyStimulus(1'b1, 32'hFFDFF06F, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutImmSrc !== 3'b011) begin errors++; $display("[TB] FAIL jal imm_src: got %b want 011", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL jal imm: got %h want fffffffc", d0OutImm); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_system_op();
        applyStimulus(1'b1, 32'h800FD073, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutImmSrc !== 3'b101) begin errors++; $display("[TB] FAIL zimm imm_src: got %b want 101", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'h0000001F) begin errors++; $display("[TB] FAIL zimm imm: got %h want 0000001f", d0OutImm); end
        checks++; if (d1OutImmSrc !== 3'b111) begin errors++; $display("[TB] FAIL no-zimm imm_src: got %b want 111", d1OutImmSrc); end
        checks++; if (d1OutImm !== 64'h0) begin errors++; $display("[TB] FAIL no-zimm imm: got %h want 0", d1OutImm); end
        checks++; if (d1OutIllegal !== 1'b0) begin errors++; $display("[TB] FAIL no-zimm illegal: got %b want 0", d1OutIllegal); end
        applyStimulus(1'b1, 32'h003100B3, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutImmSrc !== 3'b111) begin errors++; $display("[TB] FAIL op imm_src: got %b want 111", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'h0) begin errors++; $display("[TB] FAIL op imm: got %h want 0", d0OutImm); end
        checks++; if (d0OutIllegal !== 1'b0) begin errors++; $display("[TB] FAIL op illegal: got %b want 0", d0OutIllegal); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [6];
        logic [31:0] rcvd [$];
        int idx;
        for (int i = 0; i < 6; i++) begin
            words[i] = 32'h00000093 | (32'(i + 1) << 20);
        end
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            outReady = !(c >= 3 && c <= 5);
            inValid  = (idx < 6);
            inInsn   = (idx < 6) ? words[idx] : 32'h0;
            flush    = 1'b0;
            #1;
            if (d0OutValid && outReady) rcvd.push_back(d0OutInsn);
            if (c >= 3 && c <= 6) begin
                checks++; if (d0OutInsn !== words[2]) begin errors++; $display("[TB] FAIL stall hold c%0d: got %h want %h", c, d0OutInsn, words[2]); end
            end
            if (c >= 3 && c <= 5) begin
                checks++; if (d0InReady !== 1'b0) begin errors++; $display("[TB] FAIL stall in_ready c%0d: got %b want 0", c, d0InReady); end
            end
            if (inValid && d0InReady) idx++;
            @(negedge clk);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (rcvd.size() != 6) begin errors++; $display("[TB] FAIL stream count: got %0d want 6", rcvd.size()); end
        for (int i = 0; i < 6 && i < rcvd.size(); i++) begin
            checks++; if (rcvd[i] !== words[i]) begin errors++; $display("[TB] FAIL stream order %0d: got %h want %h", i, rcvd[i], words[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        applyStimulus(1'b1, 32'h00500093, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b1) begin errors++; $display("[TB] FAIL pre-flush valid: got %b want 1", d0OutValid); end
        applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL flush valid: got %b want 0", d0OutValid); end
        checks++; if (d1IllegalCnt !== 8'd0) begin errors++; $display("[TB] FAIL flush cnt: got %0d want 0", d1IllegalCnt); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (d0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL dropped word appeared: got %b want 0", d0OutValid); end
        checks++; if (d0IllegalCnt !== 2'd0) begin errors++; $display("[TB] FAIL dropped word counted: got %0d want 0", d0IllegalCnt); end
    endtask

    task automatic test_illegal_saturation();
        logic [1:0] expCnt [5];
        expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b0);
            @(negedge clk);
            checks++; if (d0OutIllegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal flag %0d: got %b want 1", k, d0OutIllegal); end
            checks++; if (d0IllegalCnt !== expCnt[k]) begin errors++; $display("[TB] FAIL sat cnt %0d: got %0d want %0d", k, d0IllegalCnt, expCnt[k]); end
            checks++; if (d1IllegalCnt !== 8'(k + 1)) begin errors++; $display("[TB] FAIL wide cnt %0d: got %0d want %0d", k, d1IllegalCnt, k + 1); end
        end
        checks++; if (d0OutImmSrc !== 3'b111) begin errors++; $display("[TB] FAIL illegal imm_src: got %b want 111", d0OutImmSrc); end
        checks++; if (d0OutImm !== 32'h0) begin errors++; $display("[TB] FAIL illegal imm: got %h want 0", d0OutImm); end
        resetn = 1'b0;
        applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (d0IllegalCnt !== 2'd0) begin errors++; $display("[TB] FAIL reset cnt2: got %0d want 0", d0IllegalCnt); end
        checks++; if (d1IllegalCnt !== 8'd0) begin errors++; $display("[TB] FAIL reset cnt8: got %0d want 0", d1IllegalCnt); end
        checks++; if (d0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset discards: got %b want 0", d0OutValid); end
        checks++; if (d0OutIllegal !== 1'b0) begin errors++; $display("[TB] FAIL reset illegal flag: got %b want 0", d0OutIllegal); end
        resetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (d0InReady !== 1'b1) begin errors++; $display("[TB] FAIL release in_ready: got %b want 1", d0InReady); end
    endtask

    // Scenario sequence.
    initial begin
        resetn   = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        inInsn   = 32'h0;
        outReady = 1'b1;
        test_reset();
        test_i_type();
        test_s_b_type();
        test_u_type();
        test_j_type();
        test_system_op();
        test_back_to_back();
        test_flush();
        test_illegal_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate datapath width; legal values 32 and 64.
REQ-002 Parameter ENABLE_ZIMM, default 1, enables CSR zero-extended immediate decode (SYSTEM opcode).
REQ-003 Parameter CNT_W, default 8, width of the illegal-opcode counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 in_valid  input  1  in_insn is valid.
REQ-008 in_ready  output  1  stage can accept in_insn this cycle.
REQ-009 in_insn  input  32  RISC-V instruction word.
REQ-010 out_valid  output  1  output register holds a decoded instruction.
REQ-011 out_ready  input  1  consumer accepts output this cycle.
REQ-012 out_insn  output  32  registered copy of accepted instruction.
REQ-013 out_imm_src  output  3  immediate type code.
REQ-014 out_imm  output  XLEN  extended immediate.
REQ-015 out_illegal  output  1  opcode not in decode table.
REQ-016 illegal_cnt  output  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-017 Decode on opcode in_insn[6:0]; imm_src codes: I 000, S 001, B 010, J 011, U 100, Z 101, none 111.
REQ-018 I (000): JALR 1100111, LOAD 0000011, OP-IMM 0010011, FENCE 0001111; imm = sext(insn[31:20]).
REQ-019 S (001): STORE 0100011; imm = sext({insn[31:25],insn[11:7]}).
REQ-020 B (010): BRANCH 1100011; imm = sext({insn[31],insn[7],insn[30:25],insn[11:8],0}).
REQ-021 J (011): JAL 1101111; imm = sext({insn[31],insn[19:12],insn[20],insn[30:21],0}).
REQ-022 U (100): LUI 0110111, AUIPC 0010111; imm = sext({insn[31:12],12'h000}) to XLEN.
REQ-023 Z (101): SYSTEM 1110011 when ENABLE_ZIMM=1; imm = zext(insn[19:15]); when ENABLE_ZIMM=0, SYSTEM decodes as none.
REQ-024 None (111): OP 0110011; imm = 0, out_illegal = 0.
REQ-025 Any other opcode: imm_src 111, imm 0, out_illegal = 1; no X values driven on any output.
REQ-026 in_ready = !out_valid || out_ready (combinational, no in_valid dependency).
REQ-027 Accept = in_valid && in_ready && !flush; on accept, out_* registers load decoded values next edge, out_valid = 1; latency exactly 1 cycle.
REQ-028 out_valid && out_ready && !accept: out_valid clears next edge.
REQ-029 Simultaneous output handshake and accept: new instruction replaces old in same edge, out_valid stays 1, no bubble.
REQ-030 out_valid && !out_ready: all out_* held stable until handshake.
REQ-031 flush: out_valid = 0 next edge; flush beats accept; in_insn presented during flush is dropped and not counted.
REQ-032 illegal_cnt increments by 1 per accepted illegal instruction; saturates at all-ones, never wraps.

Reset
REQ-033 resetn low at a rising edge: out_valid 0, out_insn 0, out_imm_src 111, out_imm 0, out_illegal 0, illegal_cnt 0.
REQ-034 Reset takes priority over flush and accept; an in-flight output is discarded; in_ready = 1 the cycle after reset releases.

Verification
REQ-035 XLEN=32, 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid 1, imm_src 000, imm 0xFFFFFFFF.
REQ-036 0x0020A423 (sw) -> imm_src 001, imm 0x00000008; 0xFE000EE3 (beq -4) -> imm_src 010, imm 0xFFFFFFFC.
REQ-037 XLEN=64, 0x123452B7 (lui) -> imm_src 100, imm 0x0000000012345000; 0x800000B7 -> imm 0xFFFFFFFF80000000.
REQ-038 Back-to-back stream, out_ready low 3 cycles mid-stream -> in_ready 0, outputs frozen 3 cycles, no instruction lost or duplicated, original order kept.
REQ-039 CNT_W=2, 5 accepted 0x0000007F -> out_illegal 1 each, illegal_cnt 1,2,3,3,3; resetn low -> illegal_cnt 0.
REQ-040 flush asserted with in_valid and out_valid high -> next cycle out_valid 0, illegal_cnt unchanged, dropped word never appears.
